// File: rtl/io_input_port.sv
// io_input_port: answers the processor's IN request. It waits for a debounced
// press of the active-low insert button, then captures the 18 switches as a
// signed 32-bit value and issues a single-cycle input_ready pulse.
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        input_flag,
  input  logic        halt,
  input  logic        insert,
  input  logic [17:0] SW,
  output logic [31:0] user_input,
  output logic        input_ready,
  output logic        waiting
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_UP = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronizer as a 2-deep shift register; sync_q[1] is btn_s (1 = pressed).
  logic [1:0]       sync_q, sync_d;
  logic             btn_s;

  // Debounced level, its one-cycle-delayed copy, and the stability counter.
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  // FSM and registered outputs.
  logic [2:0]       state_q, state_d;
  logic [31:0]      user_input_q, user_input_d;
  logic             input_ready_q, input_ready_d;
  logic             waiting_q, waiting_d;

  logic             abort;
  logic [31:0]      mag;
  logic [31:0]      captured;

  assign btn_s = sync_q[1];

  // Shift the inverted raw button into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[0], ~insert};
  end

  // Accept a new button level only after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_comb begin
    db_d     = db_q;
    cnt_d    = cnt_q;
    db_dly_d = db_q;
    if (btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = btn_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign press = db_q & ~db_dly_q;

  // Sign-magnitude switches to two's complement; -0 naturally folds to 0.
  assign mag      = {15'd0, SW[16:0]};
  assign captured = SW[17] ? ((~mag) + 32'd1) : mag;

  // Losing the request or a halt cancels a wait, even if a press lands the
  // same cycle.
  assign abort = ~input_flag | halt;

  // Request handshake: a button still held from the last request must be
  // released before it can be accepted, and only one pulse is issued per
  // input_flag assertion (HOLD waits for the flag to drop).
  always_comb begin
    state_d       = state_q;
    user_input_d  = user_input_q;
    input_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (input_flag && !halt) state_d = db_q ? ST_WAIT_UP : ST_ARM;
      end
      ST_WAIT_UP: begin
        if (abort)      state_d = ST_IDLE;
        else if (!db_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (press) begin
          state_d       = ST_ACK;
          user_input_d  = captured;
          input_ready_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!input_flag) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    waiting_d = (state_d == ST_WAIT_UP) || (state_d == ST_ARM);
  end

  // All state updates with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync_q        <= '0;
      db_q          <= 1'b0;
      db_dly_q      <= 1'b0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      user_input_q  <= '0;
      input_ready_q <= 1'b0;
      waiting_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      db_q          <= db_d;
      db_dly_q      <= db_dly_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      user_input_q  <= user_input_d;
      input_ready_q <= input_ready_d;
      waiting_q     <= waiting_d;
    end
  end

  assign user_input  = user_input_q;
  assign input_ready = input_ready_q;
  assign waiting     = waiting_q;

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with DEBOUNCE_CYCLES = 16.
module tb_io_input_port;

  localparam int D = 16;

  logic        CLK;
  logic        reset;
  logic        input_flag;
  logic        halt;
  logic        insert;
  logic [17:0] SW;
  logic [31:0] user_input;
  logic        input_ready;
  logic        waiting;

  int checks;
  int errors;
  int pulse_cnt;

  io_input_port #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .input_flag (input_flag),
    .halt       (halt),
    .insert     (insert),
    .SW         (SW),
    .user_input (user_input),
    .input_ready(input_ready),
    .waiting    (waiting)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock; outputs sampled 1 time unit after the edge, pulses tallied.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (input_ready === 1'b1) pulse_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    checks++;
    if (user_input !== 32'd0) begin errors++; $display("FAIL reset_user_input got %h want 00000000", user_input); end
    checks++;
    if (input_ready !== 1'b0) begin errors++; $display("FAIL reset_input_ready got %b want 0", input_ready); end
    checks++;
    if (waiting !== 1'b0) begin errors++; $display("FAIL reset_waiting got %b want 0", waiting); end
  endtask

  task automatic test_basic();
    int p0;
    SW = 18'h2_0005;
    input_flag = 1'b1;
    tick();
    checks++;
    if (waiting !== 1'b1) begin errors++; $display("FAIL basic_waiting got %b want 1", waiting); end
    p0 = pulse_cnt;
    insert = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == D + 2) begin
        checks++;
        if (input_ready !== 1'b0) begin errors++; $display("FAIL basic_early_pulse got %b want 0", input_ready); end
      end
      if (k == D + 3) begin
        checks++;
        if (input_ready !== 1'b1) begin errors++; $display("FAIL basic_pulse got %b want 1", input_ready); end
        checks++;
        if (user_input !== 32'hFFFF_FFFB) begin errors++; $display("FAIL basic_value got %h want fffffffb", user_input); end
      end
      if (k == D + 4) begin
        checks++;
        if (input_ready !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", input_ready); end
        checks++;
        if (waiting !== 1'b0) begin errors++; $display("FAIL basic_waiting_after got %b want 0", waiting); end
      end
    end
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL basic_pulse_count got %0d want 1", pulse_cnt - p0); end
    insert = 1'b1;
    input_flag = 1'b0;
    ticks(25);
  endtask

  task automatic test_bounce();
    int p0;
    int wait_bad;
    logic [31:0] prev;
    prev = user_input;
    input_flag = 1'b1;
    tick();
    p0 = pulse_cnt;
    wait_bad = 0;
    for (int k = 0; k < 60; k++) begin
      insert = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (waiting !== 1'b1) wait_bad++;
    end
    insert = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (waiting !== 1'b1) wait_bad++;
    end
    checks++;
    if (wait_bad != 0) begin errors++; $display("FAIL bounce_waiting low_cycles %0d want 0", wait_bad); end
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL bounce_pulse got %0d want 0", pulse_cnt - p0); end
    checks++;
    if (user_input !== prev) begin errors++; $display("FAIL bounce_value got %h want %h", user_input, prev); end
    input_flag = 1'b0;
    ticks(2);
  endtask

  task automatic test_held();
    int p0;
    insert = 1'b0;
    ticks(25);
    SW = 18'h0_0007;
    input_flag = 1'b1;
    p0 = pulse_cnt;
    tick();
    checks++;
    if (waiting !== 1'b1) begin errors++; $display("FAIL held_waiting got %b want 1", waiting); end
    ticks(30);
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL held_no_auto_accept got %0d want 0", pulse_cnt - p0); end
    checks++;
    if (user_input === 32'd7) begin errors++; $display("FAIL held_value_early got %h want not 7", user_input); end
    insert = 1'b1;
    ticks(25);
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL held_release_pulse got %0d want 0", pulse_cnt - p0); end
    insert = 1'b0;
    ticks(40);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL held_fresh_press got %0d want 1", pulse_cnt - p0); end
    checks++;
    if (user_input !== 32'd7) begin errors++; $display("FAIL held_value got %h want 00000007", user_input); end
    insert = 1'b1;
    input_flag = 1'b0;
    ticks(25);
  endtask

  // Abort lands in the cycle where btn_db has just risen (press visible).
  task automatic test_abort(input bit use_halt);
    int p0;
    SW = 18'h0_0009;
    input_flag = 1'b1;
    tick();
    p0 = pulse_cnt;
    insert = 1'b0;
    ticks(D + 2);
    if (use_halt) halt = 1'b1;
    else          input_flag = 1'b0;
    tick();
    checks++;
    if (waiting !== 1'b0) begin errors++; $display("FAIL abort%0d_waiting got %b want 0", use_halt, waiting); end
    checks++;
    if (input_ready !== 1'b0) begin errors++; $display("FAIL abort%0d_ready got %b want 0", use_halt, input_ready); end
    ticks(10);
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL abort%0d_pulse got %0d want 0", use_halt, pulse_cnt - p0); end
    checks++;
    if (user_input !== 32'd7) begin errors++; $display("FAIL abort%0d_value got %h want 00000007", use_halt, user_input); end
    insert = 1'b1;
    halt = 1'b0;
    input_flag = 1'b0;
    ticks(25);
  endtask

  task automatic test_reset_mid();
    int p0;
    SW = 18'h0_0011;
    input_flag = 1'b1;
    tick();
    p0 = pulse_cnt;
    insert = 1'b0;
    ticks(D / 2);
    reset = 1'b1;
    tick();
    checks++;
    if (user_input !== 32'd0) begin errors++; $display("FAIL rstmid_user_input got %h want 00000000", user_input); end
    checks++;
    if (waiting !== 1'b0) begin errors++; $display("FAIL rstmid_waiting got %b want 0", waiting); end
    checks++;
    if (input_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", input_ready); end
    reset = 1'b0;
    input_flag = 1'b0;
    insert = 1'b1;
    ticks(30);
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL rstmid_pulse got %0d want 0", pulse_cnt - p0); end
    checks++;
    if (user_input !== 32'd0) begin errors++; $display("FAIL rstmid_value_after got %h want 00000000", user_input); end
  endtask

  task automatic test_hold_reissue();
    int p0;
    SW = 18'h0_0003;
    input_flag = 1'b1;
    tick();
    p0 = pulse_cnt;
    insert = 1'b0; ticks(20);
    insert = 1'b1; ticks(25);
    insert = 1'b0; ticks(25);
    insert = 1'b1; ticks(30);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL hold_single_pulse got %0d want 1", pulse_cnt - p0); end
    checks++;
    if (user_input !== 32'd3) begin errors++; $display("FAIL hold_value got %h want 00000003", user_input); end
    input_flag = 1'b0;
    ticks(2);
    SW = 18'h2_0000;
    input_flag = 1'b1;
    tick();
    insert = 1'b0;
    ticks(25);
    checks++;
    if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL reissue_pulse got %0d want 2", pulse_cnt - p0); end
    checks++;
    if (user_input !== 32'd0) begin errors++; $display("FAIL reissue_neg_zero got %h want 00000000", user_input); end
    insert = 1'b1;
    input_flag = 1'b0;
    ticks(5);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulse_cnt = 0;
    reset = 1'b1;
    input_flag = 1'b0;
    halt = 1'b0;
    insert = 1'b1;
    SW = 18'd0;
    test_reset();
    test_basic();
    test_bounce();
    test_held();
    test_abort(1'b0);
    test_abort(1'b1);
    test_reset_mid();
    test_hold_reissue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
# io_input_port

Responder for the processor's user-input request. The control unit raises `input_flag` on an IN instruction and stalls the PC. This block waits for the operator to press the `insert` pushbutton, which it debounces. It then captures the 18 board switches as a signed 32-bit value on `user_input` and emits a one-cycle `input_ready` pulse that releases the stall. It sits between the board KEY/SW pins and the register-file write-back mux.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button level change is accepted. Simulation uses 16; board builds override it to about 500000.
- `CNT_W`, default 20: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `CLK`  in  1  single system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `input_flag`  in  1  level request from the control unit. Held high while the processor is stalled on IN.
- `halt`  in  1  processor halted; aborts any pending request.
- `insert`  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to `CLK`.
- `SW`  in  18  raw switches. `SW[17]` is the sign, `SW[16:0]` is the magnitude.
- `user_input`  out  32  last captured value, held until the next capture.
- `input_ready`  out  1  one-cycle pulse; the PC advances on it.
- `waiting`  out  1  high while the block is waiting for the operator (drives an LED).

## Operation
- Synchronizer: 2-FF chain on `~insert` produces `btn_s` (1 = pressed). `SW` is sampled directly at capture; the operator does not move switches while pressing.
- Debouncer: registered `btn_db` with counter `cnt`.
  - If `btn_s == btn_db`: `cnt` clears to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1`, `btn_db` takes `btn_s` on that edge and `cnt` clears to 0.
  - Any single-cycle glitch shorter than `DEBOUNCE_CYCLES` is ignored.
- `press` = `btn_db` rising, detected with a registered copy `btn_db_q`.
- FSM states: IDLE, WAIT_UP, ARM, ACK, HOLD.
  - IDLE: when `input_flag & ~halt`, go to WAIT_UP if `btn_db` = 1, else go to ARM. A button still held from a previous request must be released first, so it never auto-accepts.
  - WAIT_UP: when `btn_db` = 0, go to ARM.
  - ARM: on `press`, capture `user_input` and go to ACK.
  - ACK: `input_ready` = 1; go to HOLD unconditionally.
  - HOLD: when `input_flag` = 0, go to IDLE.
  - Abort: in WAIT_UP or ARM, `halt` = 1 or `input_flag` = 0 returns to IDLE. `user_input` is unchanged and no pulse is issued. Abort has priority over `press` in the same cycle.
  - `halt` in ACK or HOLD does not cancel the pulse already in progress.
- Capture arithmetic: `mag` = zero-extended `SW[16:0]`.
  - `SW[17]` = 0 gives `user_input` = `mag`.
  - `SW[17]` = 1 gives `user_input` = two's complement negative of `mag` (32-bit). A magnitude of 0 yields 0 regardless of sign.
- `waiting` = 1 in WAIT_UP and ARM, 0 otherwise.
- Reset values:
  - FSM in IDLE; `user_input` = 0; `input_ready` = 0; `waiting` = 0.
  - `btn_db` = 0; `btn_db_q` = 0; `cnt` = 0; synchronizer FFs = 0.
  - Reset mid-request discards the request; no pulse is issued.

## Timing
- `input_ready` is registered, high for exactly 1 cycle per accepted press, and never twice for one `input_flag` assertion.
- Press latency, counting edge 1 as the first edge that samples `insert` = 0, with the FSM in ARM and `insert` held low:
  - `btn_s` = 1 after edge 2.
  - `btn_db` = 1 after edge D+2, where D = `DEBOUNCE_CYCLES`.
  - `user_input` is valid after edge D+3, and `input_ready` is high during the cycle after edge D+3.
  - `input_ready` drops at edge D+4.
- Request to `waiting`: `waiting` is high in the cycle after the first edge that samples `input_flag` = 1.
- Abort: `waiting` is low in the cycle after the edge that samples `input_flag` = 0 or `halt` = 1.
- Release in WAIT_UP: ARM is entered one edge after `btn_db` falls. Falling `btn_db` uses the same D+2 latency as a press.

## Test plan
- Basic, signed capture: reset, `input_flag` = 1, `SW` = 18'h2_0005 (sign bit set, magnitude 5), `insert` low for 40 cycles. Required: one `input_ready` pulse at cycle D+3 after the press; `user_input` = 32'hFFFF_FFFB.
- Bounce rejection: in ARM, toggle `insert` low/high every 5 cycles for 60 cycles, then hold it high. Required: no `input_ready`, `user_input` unchanged, `waiting` = 1 throughout.
- Held button: hold `insert` low, then raise `input_flag` with `SW` = 18'h0_0007. Required: FSM goes to WAIT_UP and no pulse while the button stays held. After release, a fresh press gives `user_input` = 7 with exactly one pulse.
- Abort: in ARM, drop `input_flag` (repeat the run with `halt` = 1 instead) in the same cycle that `btn_db` rises. Required: no pulse, `user_input` keeps its previous value, `waiting` = 0 the next cycle.
- Hold/reissue: keep `input_flag` high for 100 cycles after ACK while pressing again. Required: no second pulse. Then drop and re-raise `input_flag` and press with `SW` = 18'h2_0000. Required: `user_input` = 0.
- Reset mid-debounce: assert `reset` at D/2 into a press. Required: all outputs return to their reset values and no pulse appears afterwards.
